// File: rtl/fetch_stage.sv
// XM23 fetch stage: PC + sync imem reads, DEPTH-entry word/PC FIFO to decode over valid/ready.
// Latency: word valid 2 cycles after issue; redirect flushes FIFO and drops the in-flight read.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_pc;
  logic [15:0]     r_tag_pc;
  logic            r_inflight;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_mem_inst [DEPTH];
  logic [15:0]     r_mem_pc   [DEPTH];

  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic [CW:0]     w_occ;

  assign inst_valid = (r_count != '0);
  assign inst       = inst_valid ? r_mem_inst[r_rd_ptr] : 16'h0000;
  assign inst_pc    = inst_valid ? r_mem_pc[r_rd_ptr]   : 16'h0000;
  assign imem_addr  = r_pc;
  assign imem_rd    = w_issue;

  // Occupancy counts the outstanding read so the returning word always has a slot.
  assign w_pop  = inst_valid & inst_ready & ~redirect_valid;
  assign w_push = r_inflight & ~redirect_valid;
  assign w_occ  = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fetch_enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!fetch_enable) w_state_nxt = S_IDLE;
        else if (!redirect_valid && (w_occ < LP_DEPTH)) w_issue = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC & 16'hFFFE;
      r_tag_pc   <= 16'h0000;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_pc       <= redirect_pc & 16'hFFFE;
        r_inflight <= 1'b0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_pc     <= r_pc + 16'd2;
          r_tag_pc <= r_pc;
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]   <= r_tag_pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard queue of expected {inst, pc} drained by a monitor.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic        fetch_enable;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];

  fetch_stage #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .imem_rd        (imem_rd),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory holds mem[a] = a, one-cycle read latency.
  initial imem_rdata = 16'h0000;
  always @(posedge clock) if (imem_rd) imem_rdata <= imem_addr;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] pc);
    exp_q.push_back({pc, pc});
  endtask

  task automatic step(input logic fe, input logic rdy, input logic rv, input logic [15:0] rp);
    @(posedge clock);
    #1;
    fetch_enable   = fe;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
  endtask

  always @(negedge clock) begin
    if (reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got pc %h expected none at %0t", inst_pc, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_inst", inst, e[31:16]);
        chk("sb_inst_pc", inst_pc, e[15:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; fetch_enable = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_imem_rd", {15'b0, imem_rd}, 16'd0);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    chk("rst_inst_valid", {15'b0, inst_valid}, 16'd0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_inst_pc", inst_pc, 16'h0000);

    // Stream from reset; stall 5 cycles mid-stream.
    for (int i = 0; i < 9; i++) push_exp(16'(2 * i));
    @(posedge clock); #1;
    reset = 1'b1; fetch_enable = 1'b1; inst_ready = 1'b1; #1;
    chk("idle_no_rd", {15'b0, imem_rd}, 16'd0);
    step(1, 1, 0, 0);
    chk("first_rd", {15'b0, imem_rd}, 16'd1);
    chk("first_addr", imem_addr, 16'h0000);
    step(1, 1, 0, 0);
    chk("lat_not_yet", {15'b0, inst_valid}, 16'd0);
    step(1, 1, 0, 0);
    chk("lat_valid", {15'b0, inst_valid}, 16'd1);
    repeat (4) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("full_no_rd", {15'b0, imem_rd}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      chk("stall_no_rd", {15'b0, imem_rd}, 16'd0);
      chk("stall_inst_pc", inst_pc, 16'h000A);
      chk("stall_inst", inst, 16'h000A);
    end
    repeat (4) step(1, 1, 0, 0);

    // Redirect to odd target with a word buffered and a read in flight.
    step(1, 0, 1, 16'h0101);
    chk("pre_redir_q", 16'(exp_q.size()), 16'd0);
    push_exp(16'h0100); push_exp(16'h0102); push_exp(16'h0104);
    step(1, 1, 0, 0);
    chk("redir_flush_valid", {15'b0, inst_valid}, 16'd0);
    chk("redir_rd", {15'b0, imem_rd}, 16'd1);
    chk("redir_addr", imem_addr, 16'h0100);
    repeat (4) step(1, 1, 0, 0);

    // PC wrap through 16'hFFFE.
    step(1, 0, 1, 16'hFFFC);
    chk("pre_wrap_q", 16'(exp_q.size()), 16'd0);
    push_exp(16'hFFFC); push_exp(16'hFFFE); push_exp(16'h0000);
    push_exp(16'h0002); push_exp(16'h0004); push_exp(16'h0006);
    step(1, 1, 0, 0);
    chk("wrap_addr", imem_addr, 16'hFFFC);
    repeat (5) step(1, 1, 0, 0);

    // Disable with a read in flight; the word still arrives, PC holds.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      chk("dis_no_rd", {15'b0, imem_rd}, 16'd0);
    end
    chk("dis_drained", {15'b0, inst_valid}, 16'd0);
    chk("dis_pc_held", imem_addr, 16'h0008);
    chk("dis_q", 16'(exp_q.size()), 16'd0);
    push_exp(16'h0008); push_exp(16'h000A); push_exp(16'h000C);
    step(1, 1, 0, 0);
    chk("reen_idle_no_rd", {15'b0, imem_rd}, 16'd0);
    step(1, 1, 0, 0);
    chk("reen_rd", {15'b0, imem_rd}, 16'd1);
    chk("reen_addr", imem_addr, 16'h0008);
    repeat (4) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("full2_valid", {15'b0, inst_valid}, 16'd1);
    chk("full2_no_rd", {15'b0, imem_rd}, 16'd0);
    chk("full2_head", inst_pc, 16'h000E);

    // Reset with FIFO full.
    @(posedge clock); #1;
    reset = 1'b0; #1;
    chk("mid_rst_valid", {15'b0, inst_valid}, 16'd0);
    chk("mid_rst_rd", {15'b0, imem_rd}, 16'd0);
    chk("mid_rst_inst", inst, 16'h0000);
    chk("mid_rst_q", 16'(exp_q.size()), 16'd0);
    repeat (2) @(posedge clock);
    for (int i = 0; i < 5; i++) push_exp(16'(2 * i));
    @(posedge clock); #1;
    reset = 1'b1; fetch_enable = 1'b1; inst_ready = 1'b1; #1;
    begin
      int k;
      k = 0;
      while (!imem_rd && k < 5) begin
        step(1, 1, 0, 0);
        k++;
      end
      chk("post_rst_rd_seen", {15'b0, imem_rd}, 16'd1);
      chk("post_rst_addr", imem_addr, 16'h0000);
    end
    repeat (4) step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    chk("final_q", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
